// File: rtl/mem_req_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single memory request port.
// Optional round-robin arbitration is compiled in with `define MEM_ARB_RR_EN.
module mem_req_arbiter #(
  parameter int XLEN  = 32,
  parameter int BYTES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  i_addr,
  input  logic             i_valid,
  output logic [XLEN-1:0]  i_data_out,
  output logic             i_done,
  input  logic [XLEN-1:0]  d_addr,
  input  logic [XLEN-1:0]  d_data_in,
  input  logic             d_wr,
  input  logic             d_rd,
  input  logic             d_valid,
  input  logic [BYTES-1:0] d_be,
  output logic [XLEN-1:0]  d_data_out,
  output logic             d_done,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_data_in,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic             mem_valid,
  output logic [BYTES-1:0] mem_be,
  input  logic [XLEN-1:0]  mem_data_out,
  input  logic             mem_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_gnt_d, w_gnt_d_nxt;
  logic [XLEN-1:0]  r_mem_addr, w_mem_addr_nxt;
  logic [XLEN-1:0]  r_mem_data_in, w_mem_data_in_nxt;
  logic             r_mem_wr, w_mem_wr_nxt;
  logic             r_mem_rd, w_mem_rd_nxt;
  logic             r_mem_valid, w_mem_valid_nxt;
  logic [BYTES-1:0] r_mem_be, w_mem_be_nxt;
  logic [XLEN-1:0]  r_i_data_out, w_i_data_out_nxt;
  logic [XLEN-1:0]  r_d_data_out, w_d_data_out_nxt;
  logic             r_i_done, w_i_done_nxt;
  logic             r_d_done, w_d_done_nxt;
  logic             w_d_req, w_i_req, w_pick_d;

  // A D request with neither rd nor wr set is not a request at all.
  assign w_d_req = d_valid & (d_wr | d_rd);
  assign w_i_req = i_valid;

`ifdef MEM_ARB_RR_EN
  logic r_last_d, w_last_d_nxt;

  // On contention, the port that did not win last time gets the grant.
  assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);

  // Last-grant pointer advances on every grant out of IDLE.
  always_comb begin
    w_last_d_nxt = r_last_d;
    if ((r_state == S_IDLE) && (w_d_req || w_i_req)) begin
      w_last_d_nxt = w_pick_d;
    end else begin
      w_last_d_nxt = r_last_d;
    end
  end

  // Pointer register; starts out pointing at I so D wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else begin
      r_last_d <= w_last_d_nxt;
    end
  end
`else
  assign w_pick_d = w_d_req;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt       = r_state;
    w_gnt_d_nxt       = r_gnt_d;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_data_in_nxt = r_mem_data_in;
    w_mem_wr_nxt      = r_mem_wr;
    w_mem_rd_nxt      = r_mem_rd;
    w_mem_valid_nxt   = r_mem_valid;
    w_mem_be_nxt      = r_mem_be;
    w_i_data_out_nxt  = r_i_data_out;
    w_d_data_out_nxt  = r_d_data_out;
    w_i_done_nxt      = 1'b0;
    w_d_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_d_req || w_i_req) begin
          w_state_nxt     = S_ISSUE;
          w_mem_valid_nxt = 1'b1;
          w_gnt_d_nxt     = w_pick_d;
          if (w_pick_d) begin
            w_mem_addr_nxt    = d_addr;
            w_mem_data_in_nxt = d_data_in;
            w_mem_wr_nxt      = d_wr;
            w_mem_rd_nxt      = ~d_wr;
            w_mem_be_nxt      = d_be;
          end else begin
            w_mem_addr_nxt    = i_addr;
            w_mem_data_in_nxt = {XLEN{1'b0}};
            w_mem_wr_nxt      = 1'b0;
            w_mem_rd_nxt      = 1'b1;
            w_mem_be_nxt      = {BYTES{1'b1}};
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (mem_done) begin
          w_state_nxt     = S_RESP;
          w_mem_valid_nxt = 1'b0;
          w_mem_rd_nxt    = 1'b0;
          w_mem_wr_nxt    = 1'b0;
          if (r_gnt_d) begin
            w_d_done_nxt     = 1'b1;
            w_d_data_out_nxt = r_mem_wr ? {XLEN{1'b0}} : mem_data_out;
          end else begin
            w_i_done_nxt     = 1'b1;
            w_i_data_out_nxt = mem_data_out;
          end
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_gnt_d       <= 1'b0;
      r_mem_addr    <= {XLEN{1'b0}};
      r_mem_data_in <= {XLEN{1'b0}};
      r_mem_wr      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_valid   <= 1'b0;
      r_mem_be      <= {BYTES{1'b0}};
      r_i_data_out  <= {XLEN{1'b0}};
      r_d_data_out  <= {XLEN{1'b0}};
      r_i_done      <= 1'b0;
      r_d_done      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_gnt_d       <= w_gnt_d_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_data_in <= w_mem_data_in_nxt;
      r_mem_wr      <= w_mem_wr_nxt;
      r_mem_rd      <= w_mem_rd_nxt;
      r_mem_valid   <= w_mem_valid_nxt;
      r_mem_be      <= w_mem_be_nxt;
      r_i_data_out  <= w_i_data_out_nxt;
      r_d_data_out  <= w_d_data_out_nxt;
      r_i_done      <= w_i_done_nxt;
      r_d_done      <= w_d_done_nxt;
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_data_in;
  assign mem_wr      = r_mem_wr;
  assign mem_rd      = r_mem_rd;
  assign mem_valid   = r_mem_valid;
  assign mem_be      = r_mem_be;
  assign i_data_out  = r_i_data_out;
  assign d_data_out  = r_d_data_out;
  assign i_done      = r_i_done;
  assign d_done      = r_d_done;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single AXI-Lite-backed memory system request port between two requesters: instruction fetch (port I, read-only) and load/store (port D).
- Sits between the core pipeline and the memory-system wrapper.
- Accepts one request at a time, holds the memory request stable until the memory system signals done, then returns data and a one-cycle done pulse to the granted requester.
- Fixed data-first priority by default; round-robin when the optional feature is compiled in.

Parameters:
- XLEN, 32, address/data width
- BYTES, 4, byte-enable width (XLEN/8)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- i_addr  input  XLEN  fetch address
- i_valid  input  1  fetch request (read)
- i_data_out  output  XLEN  fetch read data
- i_done  output  1  fetch completion pulse
- d_addr  input  XLEN  load/store address
- d_data_in  input  XLEN  store data
- d_wr  input  1  store
- d_rd  input  1  load
- d_valid  input  1  load/store request
- d_be  input  BYTES  store byte enables
- d_data_out  output  XLEN  load data
- d_done  output  1  load/store completion pulse
- mem_addr  output  XLEN  to memory system
- mem_data_in  output  XLEN  to memory system
- mem_wr  output  1  to memory system
- mem_rd  output  1  to memory system
- mem_valid  output  1  to memory system
- mem_be  output  BYTES  to memory system
- mem_data_out  input  XLEN  from memory system
- mem_done  input  1  from memory system, one-cycle pulse

Interface decisions:
- One clock; reset is asynchronous and active-high.
- All outputs are registered.

Behaviour:
- Reset:
  - State goes to IDLE; all outputs are 0.
  - Round-robin pointer (if present) is set to I.
  - A transaction in flight is dropped; the memory system must be reset in the same cycle.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Samples i_valid and d_valid.
  - If neither is high, stay in IDLE.
  - Otherwise grant one requester and latch its addr, data, wr/rd and be into the mem_* registers.
  - Set mem_valid=1 and go to ISSUE, so mem_valid is visible in the cycle after sampling.
- Port I grant: mem_rd=1, mem_wr=0, mem_be=all ones, mem_data_in=0.
- Port D grant:
  - If d_wr=1, mem_wr=1 and mem_rd=0, even if d_rd=1.
  - If d_wr=0 and d_rd=1, it is a read.
  - If d_valid=1 with d_wr=d_rd=0, the request is ignored: no grant, and port D is treated as idle.
- ISSUE:
  - mem_* held constant; requester input changes are ignored.
  - On mem_done=1: latch mem_data_out into the granted requester's data_out, clear mem_valid, mem_rd and mem_wr, and go to RESP.
  - A write returns data_out=0.
- RESP:
  - Granted requester's done=1 for exactly this cycle; go to IDLE.
  - data_out holds its value until the next completion on that port.
- Latency: if mem_done arrives in the first cycle mem_valid is high, done is seen 2 cycles after valid was sampled. In general, done is seen N+1 cycles after valid, where N is the number of ISSUE cycles.
- Requester rule: valid is held until done. A valid still high in the IDLE cycle after RESP is a new back-to-back request.
- Simultaneous i_valid and d_valid in IDLE (default): D wins. I waits with i_valid held and is granted in the next IDLE where D is not requesting.
- Only one outstanding transaction exists; there is no queueing or buffering of the losing request's fields.
- mem_done while in IDLE or RESP is ignored.
- i_done and d_done are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: a 1-bit last-grant pointer, updated on every grant. On simultaneous requests, the port not granted last wins, so alternating contention yields D, I, D, I.
- Undefined: fixed priority, D before I, and the pointer logic is absent.

Test Plan:
1. Fetch read: i_valid=1, i_addr=0x0000_1000; memory returns 0xDEAD_BEEF with mem_done 3 cycles after mem_valid -> mem_rd=1, mem_be=4'hF, mem_addr=0x1000; i_done pulses 1 cycle with i_data_out=0xDEAD_BEEF; d_done stays 0.
2. Store with be: d_valid=1, d_wr=1, d_addr=0x2004, d_data_in=0x1234_5678, d_be=4'b0011 -> mem_wr=1, mem_be=4'b0011, mem fields stable through ISSUE; d_done 1 cycle after mem_done; d_data_out=0.
3. Contention, default build: i_valid and d_valid rise in the same cycle and are held -> D serviced first, then I; exactly two done pulses, d_done before i_done.
4. Contention with MEM_ARB_RR_EN: both ports hold valid for 4 transactions -> grant order D, I, D, I.
5. Back-to-back with zero-wait memory: mem_done in the first ISSUE cycle; a d_valid load held for 2 requests -> done pulses 3 cycles apart; d_rd=1 and d_wr=1 together -> treated as a write.
6. Reset mid-op: assert rst during ISSUE -> mem_valid, mem_rd, mem_wr and both done outputs are 0 asynchronously; after release with no valids, state stays IDLE and no done pulse appears.
